// File: rtl/dcache_assoc.sv
// Set-associative write-back/write-allocate data cache with round-robin replacement,
// one line-wide memory port for evict/fill, and an uncached IO bypass.
// state  | meaning
// IDLE   | ready, accept a request
// LOOKUP | tag compare; respond on hit, pick a victim on miss
// EVICT  | write the dirty victim line back
// FILL   | fetch the requested line into the victim way
// UNC    | uncached access on the IO port
module dcache_assoc #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 32,
    parameter int WAYS       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic                    req_uc,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [31:0]             req_wdata,
    input  logic [3:0]              req_be,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    mem_req_valid,
    output logic                    mem_req_we,
    output logic [ADDR_W-1:0]       mem_req_addr,
    output logic [8*LINE_BYTES-1:0] mem_req_wdata,
    input  logic                    mem_ack,
    input  logic [8*LINE_BYTES-1:0] mem_rdata,
    output logic                    io_access,
    output logic                    io_rw,
    output logic [ADDR_W-1:0]       io_addr,
    output logic [31:0]             io_wr_data,
    output logic [3:0]              io_be,
    input  logic [31:0]             io_rd_data,
    input  logic                    io_ack
);
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WORDS  = LINE_BYTES / 4;
    localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, UNC} state_t;

    state_t state_q, state_d;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic [PTR_W-1:0]  v_way;
    logic              v_inv;

    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [PTR_W-1:0]  ptr_q   [SETS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];

    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_tag;
    logic [WSEL_W-1:0] r_wsel;

    assign r_idx = r_addr[OFF_W +: IDX_W];
    assign r_tag = r_addr[OFF_W+IDX_W +: TAG_W];

    if (WORDS > 1) begin : g_wsel
        assign r_wsel = r_addr[2 +: WSEL_W];
    end else begin : g_wsel_one
        assign r_wsel = '0;
    end

    logic             hit, any_inv;
    logic [PTR_W-1:0] hit_way, inv_way, victim;
    logic [31:0]      hit_word, merged;

    // Descending scan leaves the lowest-index invalid way in inv_way.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[r_idx][w]) begin
                any_inv = 1'b1;
                inv_way = PTR_W'(w);
            end
            if (valid_q[r_idx][w] && (tag_q[r_idx][w] == r_tag)) begin
                hit     = 1'b1;
                hit_way = PTR_W'(w);
            end
        end
        victim   = any_inv ? inv_way : ptr_q[r_idx];
        hit_word = data_q[r_idx][hit_way][{r_wsel, 5'b0} +: 32];
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = r_be[b] ? r_wdata[8*b +: 8] : hit_word[8*b +: 8];
        end
    end

    logic hit_wr, fill_done;

    always_comb begin
        state_d   = state_q;
        hit_wr    = 1'b0;
        fill_done = 1'b0;
        case (state_q)
            IDLE:   if (req_valid) state_d = req_uc ? UNC : LOOKUP;
            LOOKUP: begin
                if (hit) begin
                    hit_wr  = r_we;
                    state_d = IDLE;
                end else if (!any_inv && dirty_q[r_idx][victim]) begin
                    state_d = EVICT;
                end else begin
                    state_d = FILL;
                end
            end
            EVICT:  if (mem_ack) state_d = FILL;
            FILL: begin
                if (mem_ack) begin
                    fill_done = 1'b1;
                    state_d   = LOOKUP;
                end
            end
            UNC:    if (io_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready     = (state_q == IDLE) && !rst;
    assign mem_req_valid = (state_q == EVICT) || (state_q == FILL);
    assign mem_req_we    = (state_q == EVICT);
    assign mem_req_addr  = (state_q == EVICT) ? {tag_q[r_idx][v_way], r_idx, {OFF_W{1'b0}}} :
                           (state_q == FILL)  ? {r_tag, r_idx, {OFF_W{1'b0}}} : '0;
    assign mem_req_wdata = (state_q == EVICT) ? data_q[r_idx][v_way] : '0;
    assign io_access     = (state_q == UNC);
    assign io_rw         = (state_q == UNC) && r_we;
    assign io_addr       = (state_q == UNC) ? r_addr : '0;
    assign io_wr_data    = (state_q == UNC) ? r_wdata : '0;
    assign io_be         = (state_q == UNC) ? r_be : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            v_way     <= '0;
            v_inv     <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            rsp_valid <= 1'b0;
            if (req_valid && (state_q == IDLE)) begin
                r_we    <= req_we;
                r_addr  <= req_addr & ~ADDR_W'(3);
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if ((state_q == LOOKUP) && hit) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= r_we ? merged : hit_word;
                if (r_we) dirty_q[r_idx][hit_way] <= 1'b1;
            end
            if ((state_q == LOOKUP) && !hit) begin
                v_way <= victim;
                v_inv <= any_inv;
            end
            if (fill_done) begin
                valid_q[r_idx][v_way] <= 1'b1;
                dirty_q[r_idx][v_way] <= 1'b0;
                if (!v_inv) ptr_q[r_idx] <= (v_way == PTR_W'(WAYS - 1)) ? '0 : v_way + 1'b1;
            end
            if ((state_q == UNC) && io_ack) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= r_we ? r_wdata : io_rd_data;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (hit_wr) data_q[r_idx][hit_way][{r_wsel, 5'b0} +: 32] <= merged;
        if (fill_done) begin
            data_q[r_idx][v_way] <= mem_rdata;
            tag_q[r_idx][v_way]  <= r_tag;
        end
    end
endmodule
